// File: rtl/clause_dispatch_buffer.sv
// Non-destructive clause store feeding NUM_ENGINE BCP lanes with in-order prefix dispatch and a broadcast UC.
// Lane outputs depend only on registered head/tail/state; a stalled lane blocks itself and all higher lanes.
module clause_dispatch_buffer #(
    parameter int LIT_IDX_MAX = 1024,
    parameter int CLA_LENGTH  = 3,
    parameter int NUM_ENGINE  = 4,
    parameter int DEPTH       = 1024,
    localparam int VAR_W      = $clog2(LIT_IDX_MAX) + 1,
    localparam int CLA_W      = VAR_W * CLA_LENGTH,
    localparam int PTR_W      = $clog2(DEPTH) + 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush_in,
    input  logic                             load_valid_in,
    input  logic [CLA_W-1:0]                 load_clause_in,
    output logic                             load_ready_out,
    input  logic                             start_in,
    input  logic                             rewind_in,
    input  logic                             chosen_uc_valid_in,
    input  logic [VAR_W-1:0]                 chosen_uc_in,
    input  logic [NUM_ENGINE-1:0]            eng_ready_in,
    output logic [NUM_ENGINE-1:0]            eng_valid_out,
    output logic [NUM_ENGINE-1:0][CLA_W-1:0] eng_clause_out,
    output logic [VAR_W-1:0]                 chosen_uc_out,
    output logic                             chosen_uc_valid_out,
    output logic [PTR_W-1:0]                 count_out,
    output logic                             empty_out,
    output logic                             full_out,
    output logic                             overflow_err_out,
    output logic                             round_done_out
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [PTR_W-1:0]     w_head_nxt;
    logic [PTR_W-1:0]     w_tail_nxt;
    logic [VAR_W-1:0]     r_uc;
    logic                 r_overflow;
    logic                 r_round_done;
    logic                 w_round_done_set;
    logic                 w_load_fire;
    logic                 w_full;
    logic [PTR_W:0]       w_k;
    logic [PTR_W:0]       w_head_sum;
    logic                 w_stop;
    logic [NUM_ENGINE-1:0] w_lane_vld;
    logic [PTR_W:0]       w_idx [NUM_ENGINE];
    logic [CLA_W-1:0]     r_mem [DEPTH];

    assign w_full         = (r_tail == PTR_W'(DEPTH));
    assign load_ready_out = (r_state == ST_IDLE) && !w_full;
    assign w_load_fire    = load_valid_in && load_ready_out && !flush_in;

    // Lane i looks at clause head+i; the extra pointer bit keeps the compare exact near DEPTH.
    always_comb begin
        for (int i = 0; i < NUM_ENGINE; i++) begin
            w_idx[i]          = {1'b0, r_head} + (PTR_W+1)'(i);
            w_lane_vld[i]     = (r_state == ST_DISPATCH) && (w_idx[i] < {1'b0, r_tail});
            eng_clause_out[i] = w_lane_vld[i] ? r_mem[w_idx[i][AW-1:0]] : '0;
        end
    end

    assign eng_valid_out = w_lane_vld;

    always_comb begin
        w_k    = '0;
        w_stop = 1'b0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (!w_stop && w_lane_vld[i] && eng_ready_in[i]) begin
                w_k = w_k + (PTR_W+1)'(1);
            end else begin
                w_stop = 1'b1;
            end
        end
    end

    assign w_head_sum = {1'b0, r_head} + w_k;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_head_nxt       = r_head;
        w_round_done_set = 1'b0;
        if (flush_in) begin
            w_state_nxt = ST_IDLE;
            w_head_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        w_state_nxt = ST_DISPATCH;
                        w_head_nxt  = '0;
                    end
                end
                ST_DISPATCH: begin
                    if (rewind_in) begin
                        w_head_nxt = '0;
                    end else begin
                        w_head_nxt = w_head_sum[PTR_W-1:0];
                        if (w_head_sum == {1'b0, r_tail}) begin
                            w_state_nxt      = ST_DONE;
                            w_round_done_set = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (rewind_in) begin
                        w_state_nxt = ST_DISPATCH;
                        w_head_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_head_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_tail_nxt = r_tail;
        if (flush_in) begin
            w_tail_nxt = '0;
        end else if (w_load_fire) begin
            w_tail_nxt = r_tail + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_uc         <= '0;
            r_overflow   <= 1'b0;
            r_round_done <= 1'b0;
        end else begin
            r_head       <= w_head_nxt;
            r_tail       <= w_tail_nxt;
            r_round_done <= w_round_done_set;
            if (chosen_uc_valid_in) begin
                r_uc <= chosen_uc_in;
            end
            if (load_valid_in && !load_ready_out) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is never cleared; head/tail alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_load_fire) begin
            r_mem[r_tail[AW-1:0]] <= load_clause_in;
        end
    end

    assign chosen_uc_valid_out = (r_state == ST_DISPATCH);
    assign chosen_uc_out       = (r_state == ST_DISPATCH) ? r_uc : '0;
    assign count_out           = r_tail;
    assign empty_out           = (r_head == r_tail);
    assign full_out            = w_full;
    assign overflow_err_out    = r_overflow;
    assign round_done_out      = r_round_done;

endmodule

// File: tb/tb_clause_dispatch_buffer.sv
// Bench for clause_dispatch_buffer: loaded clauses are queued and matched against lane outputs as they dispatch.
module tb_clause_dispatch_buffer;

    localparam int VAR_W = 11;
    localparam int CLA_W = 33;
    localparam int NE    = 4;
    localparam int DEPTH = 1024;
    localparam int PTR_W = 11;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     flush_in;
    logic                     load_valid_in;
    logic [CLA_W-1:0]         load_clause_in;
    logic                     load_ready_out;
    logic                     start_in;
    logic                     rewind_in;
    logic                     chosen_uc_valid_in;
    logic [VAR_W-1:0]         chosen_uc_in;
    logic [NE-1:0]            eng_ready_in;
    logic [NE-1:0]            eng_valid_out;
    logic [NE-1:0][CLA_W-1:0] eng_clause_out;
    logic [VAR_W-1:0]         chosen_uc_out;
    logic                     chosen_uc_valid_out;
    logic [PTR_W-1:0]         count_out;
    logic                     empty_out;
    logic                     full_out;
    logic                     overflow_err_out;
    logic                     round_done_out;

    int checks = 0;
    int errors = 0;
    logic [CLA_W-1:0] stored[$];
    logic [CLA_W-1:0] sb[$];
    logic [VAR_W-1:0] exp_uc;

    always #5 clock = ~clock;

    clause_dispatch_buffer dut (
        .clock(clock), .reset(reset), .flush_in(flush_in),
        .load_valid_in(load_valid_in), .load_clause_in(load_clause_in),
        .load_ready_out(load_ready_out), .start_in(start_in), .rewind_in(rewind_in),
        .chosen_uc_valid_in(chosen_uc_valid_in), .chosen_uc_in(chosen_uc_in),
        .eng_ready_in(eng_ready_in), .eng_valid_out(eng_valid_out),
        .eng_clause_out(eng_clause_out), .chosen_uc_out(chosen_uc_out),
        .chosen_uc_valid_out(chosen_uc_valid_out), .count_out(count_out),
        .empty_out(empty_out), .full_out(full_out),
        .overflow_err_out(overflow_err_out), .round_done_out(round_done_out)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        exp_uc = '0;
        stored.delete();
        sb.delete();
    endtask

    task automatic do_flush;
        flush_in = 1'b1;
        tick;
        flush_in = 1'b0;
        stored.delete();
        sb.delete();
    endtask

    task automatic load_clauses(input int n);
        for (int j = 0; j < n; j++) begin
            logic [CLA_W-1:0] c;
            c = CLA_W'({$urandom(), $urandom()});
            load_valid_in  = 1'b1;
            load_clause_in = c;
            tick;
            stored.push_back(c);
        end
        load_valid_in = 1'b0;
    endtask

    task automatic start_round(input logic use_rewind);
        if (use_rewind) rewind_in = 1'b1;
        else            start_in  = 1'b1;
        tick;
        rewind_in = 1'b0;
        start_in  = 1'b0;
        sb = stored;
    endtask

    task automatic run_dispatch(input logic [NE-1:0] rdy, input int budget, output int cycles);
        int k;
        bit stop;
        bit fin;
        bit ev;
        cycles = 0;
        fin = 1'b0;
        eng_ready_in = rdy;
        while (!fin && cycles < budget) begin
            checks++;
            if (chosen_uc_valid_out !== 1'b1 || chosen_uc_out !== exp_uc) begin
                errors++;
                $display("FAIL uc_dispatch cyc %0d: got vld=%b uc=%h, want vld=1 uc=%h",
                         cycles, chosen_uc_valid_out, chosen_uc_out, exp_uc);
            end
            checks++;
            if (round_done_out !== 1'b0) begin
                errors++;
                $display("FAIL round_done_early cyc %0d: got %b, want 0", cycles, round_done_out);
            end
            k = 0;
            stop = 1'b0;
            for (int i = 0; i < NE; i++) begin
                ev = (i < sb.size());
                checks++;
                if (eng_valid_out[i] !== ev) begin
                    errors++;
                    $display("FAIL lane_valid cyc %0d lane %0d: got %b, want %b",
                             cycles, i, eng_valid_out[i], ev);
                end
                checks++;
                if (ev) begin
                    if (eng_clause_out[i] !== sb[i]) begin
                        errors++;
                        $display("FAIL lane_clause cyc %0d lane %0d: got %h, want %h",
                                 cycles, i, eng_clause_out[i], sb[i]);
                    end
                end else if (eng_clause_out[i] !== '0) begin
                    errors++;
                    $display("FAIL lane_zero cyc %0d lane %0d: got %h, want 0",
                             cycles, i, eng_clause_out[i]);
                end
                if (!stop && ev && rdy[i]) k++;
                else stop = 1'b1;
            end
            for (int i = 0; i < k; i++) void'(sb.pop_front());
            fin = (sb.size() == 0);
            tick;
            cycles++;
        end
        eng_ready_in = '0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL dispatch_timeout: %0d clauses left after %0d cycles, want 0", sb.size(), cycles);
        end
        checks++;
        if (round_done_out !== 1'b1) begin
            errors++;
            $display("FAIL round_done: got %b, want 1", round_done_out);
        end
        checks++;
        if (eng_valid_out !== '0 || chosen_uc_valid_out !== 1'b0 || chosen_uc_out !== '0) begin
            errors++;
            $display("FAIL done_state: got lanes=%b ucv=%b uc=%h, want 0 0 0",
                     eng_valid_out, chosen_uc_valid_out, chosen_uc_out);
        end
        tick;
        checks++;
        if (round_done_out !== 1'b0) begin
            errors++;
            $display("FAIL round_done_pulse: got %b one cycle later, want 0", round_done_out);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (load_ready_out !== 1'b1 || empty_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_empty: got rdy=%b empty=%b, want 1 1", load_ready_out, empty_out);
        end
        checks++;
        if (count_out !== '0 || full_out !== 1'b0 || overflow_err_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_count_flags: got cnt=%0d full=%b ovf=%b, want 0 0 0",
                     count_out, full_out, overflow_err_out);
        end
        checks++;
        if (eng_valid_out !== '0 || chosen_uc_valid_out !== 1'b0 || chosen_uc_out !== '0 ||
            round_done_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got lanes=%b ucv=%b uc=%h done=%b, want all 0",
                     eng_valid_out, chosen_uc_valid_out, chosen_uc_out, round_done_out);
        end
    endtask

    task automatic test_basic;
        int cyc;
        load_clauses(6);
        checks++;
        if (count_out !== PTR_W'(6) || empty_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got cnt=%0d empty=%b, want 6 0", count_out, empty_out);
        end
        start_round(1'b0);
        run_dispatch(4'b1111, 20, cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL basic_cycles: got %0d, want 2", cyc);
        end
    endtask

    task automatic test_rewind_uc;
        int cyc;
        load_valid_in  = 1'b1;
        load_clause_in = '1;
        tick;
        load_valid_in  = 1'b0;
        checks++;
        if (overflow_err_out !== 1'b1 || count_out !== PTR_W'(6)) begin
            errors++;
            $display("FAIL load_in_done: got ovf=%b cnt=%0d, want 1 6", overflow_err_out, count_out);
        end
        chosen_uc_valid_in = 1'b1;
        chosen_uc_in       = 11'h405;
        start_round(1'b1);
        chosen_uc_valid_in = 1'b0;
        exp_uc = 11'h405;
        run_dispatch(4'b1111, 20, cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL rewind_cycles: got %0d, want 2", cyc);
        end
    endtask

    task automatic test_flush_mid;
        do_flush;
        load_clauses(6);
        start_round(1'b0);
        eng_ready_in = '0;
        checks++;
        if (eng_valid_out !== 4'hF || eng_clause_out[0] !== stored[0]) begin
            errors++;
            $display("FAIL stall_lanes: got lanes=%b c0=%h, want 1111 %h",
                     eng_valid_out, eng_clause_out[0], stored[0]);
        end
        tick;
        checks++;
        if (eng_valid_out !== 4'hF || eng_clause_out[0] !== stored[0]) begin
            errors++;
            $display("FAIL stall_hold: got lanes=%b c0=%h, want 1111 %h",
                     eng_valid_out, eng_clause_out[0], stored[0]);
        end
        do_flush;
        checks++;
        if (count_out !== '0 || empty_out !== 1'b1 || load_ready_out !== 1'b1 ||
            chosen_uc_valid_out !== 1'b0 || eng_valid_out !== '0) begin
            errors++;
            $display("FAIL flush_state: got cnt=%0d empty=%b rdy=%b ucv=%b lanes=%b, want 0 1 1 0 0",
                     count_out, empty_out, load_ready_out, chosen_uc_valid_out, eng_valid_out);
        end
        checks++;
        if (overflow_err_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_ovf: got %b, want 1", overflow_err_out);
        end
    endtask

    task automatic test_partial_ready;
        int cyc;
        load_clauses(6);
        start_round(1'b0);
        run_dispatch(4'b1011, 20, cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL partial_cycles: got %0d, want 3", cyc);
        end
        do_flush;
    endtask

    task automatic test_empty_start;
        int cyc;
        start_round(1'b0);
        run_dispatch(4'b1111, 5, cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL empty_cycles: got %0d, want 1", cyc);
        end
        do_flush;
    endtask

    task automatic test_fill;
        int cyc;
        reset_dut;
        checks++;
        if (overflow_err_out !== 1'b0 || chosen_uc_out !== '0) begin
            errors++;
            $display("FAIL reset_clears: got ovf=%b uc=%h, want 0 0", overflow_err_out, chosen_uc_out);
        end
        load_clauses(DEPTH);
        checks++;
        if (full_out !== 1'b1 || load_ready_out !== 1'b0 || count_out !== PTR_W'(DEPTH)) begin
            errors++;
            $display("FAIL fill_full: got full=%b rdy=%b cnt=%0d, want 1 0 %0d",
                     full_out, load_ready_out, count_out, DEPTH);
        end
        checks++;
        if (overflow_err_out !== 1'b0) begin
            errors++;
            $display("FAIL fill_no_ovf: got %b, want 0", overflow_err_out);
        end
        load_valid_in  = 1'b1;
        load_clause_in = '0;
        tick;
        load_valid_in  = 1'b0;
        checks++;
        if (overflow_err_out !== 1'b1 || count_out !== PTR_W'(DEPTH)) begin
            errors++;
            $display("FAIL fill_overflow: got ovf=%b cnt=%0d, want 1 %0d",
                     overflow_err_out, count_out, DEPTH);
        end
        start_round(1'b0);
        run_dispatch(4'b1111, 300, cyc);
        checks++;
        if (cyc != DEPTH / NE) begin
            errors++;
            $display("FAIL full_round_cycles: got %0d, want %0d", cyc, DEPTH / NE);
        end
    endtask

    initial begin
        reset              = 1'b1;
        flush_in           = 1'b0;
        load_valid_in      = 1'b0;
        load_clause_in     = '0;
        start_in           = 1'b0;
        rewind_in          = 1'b0;
        chosen_uc_valid_in = 1'b0;
        chosen_uc_in       = '0;
        eng_ready_in       = '0;
        exp_uc             = '0;
        reset_dut;
        test_reset;
        test_basic;
        test_rewind_uc;
        test_flush_mid;
        test_partial_ready;
        test_empty_start;
        test_fill;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
